alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, program buffer entries (power of two).
REQ-002 Parameter SETTLE, default 2, cycles ALU outputs settle before capture (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  opcode write request.
REQ-006 load_opcode  input  6  opcode to append to program.
REQ-007 load_ready  output  1  buffer accepts a write this cycle.
REQ-008 clear  input  1  empty the program (IDLE only).
REQ-009 start  input  1  begin run of stored program.
REQ-010 busy  output  1  run in progress (state != IDLE).
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 count  output  $clog2(DEPTH)+1  stored opcode count.
REQ-013 alu_opcode  output  6  registered opcode driven to ALU.
REQ-014 alu_result, alu_carry, alu_slt, alu_iszero  input  1 each  ALU outputs.
REQ-015 rsp_valid  output  1  captured response available.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_data  output  10  {opcode[5:0], result, carry, slt, iszero}.

Function
REQ-018 load_ready SHALL be 1 iff state IDLE and count < DEPTH; write occurs on load_valid && load_ready, entry at index count, count increments.
REQ-019 clear in IDLE SHALL set count to 0 next edge; clear has priority over a same-cycle write; ignored outside IDLE.
REQ-020 FSM states: IDLE, ISSUE, SETTLE, HOLD, DONE.
REQ-021 IDLE: start with count>0 -> ISSUE, index=0; start with count=0 -> DONE directly (no response); start has priority over load and clear.
REQ-022 ISSUE: alu_opcode <= prog[index], settle counter <= SETTLE-1; -> SETTLE.
REQ-023 SETTLE: counter decrements each cycle; at 0, rsp_data <= {alu_opcode, ALU outputs}, rsp_valid <= 1; -> HOLD.
REQ-024 Latency: start sampled at edge k -> alu_opcode valid from k+1 -> rsp_valid at edge k+1+SETTLE.
REQ-025 HOLD: rsp_valid and rsp_data SHALL stay stable until rsp_valid && rsp_ready at an edge; then rsp_valid <= 0, and index==count-1 -> DONE, else index+1 -> ISSUE.
REQ-026 DONE: done=1 for exactly one cycle; -> IDLE. alu_opcode retains last value.
REQ-027 start while busy SHALL be ignored; program contents and count SHALL survive a run (rerun repeats identical sequence).
REQ-028 Index wraps never: index width $clog2(DEPTH), run ends at count-1; count==DEPTH full run legal.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, count 0, index 0, alu_opcode 6'b000000, rsp_valid 0, rsp_data 0, done 0, busy 0; buffer contents undefined.
REQ-030 Reset mid-run SHALL abort without emitting further responses; a pending rsp_valid drops at once.

Structure
REQ-031 Shared package holds OPW=6, RSP_W=10, FSM state enum, and rsp_data field offsets.
REQ-032 One sub-module natural: alu_prog_buf (DEPTH x 6 register array, write port, async read port); FSM and capture in top.

Verification (bench instantiates ALU as DUT load)
REQ-033 Load 000011, 000100, 001011; start; rsp_ready=1 -> three responses in order, opcode fields 000011/000100/001011, first rsp_valid at start+1+SETTLE, done pulse after third.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles during HOLD -> rsp_data unchanged, alu_opcode unchanged, no advance.
REQ-035 Load 8 opcodes -> load_ready=0, 9th write (011010) dropped, count=8; run yields 8 responses.
REQ-036 start with count=0 -> done one cycle later, rsp_valid never asserts.
REQ-037 rst_n low during SETTLE of 2nd opcode (110001) -> rsp_valid 0, busy 0, count 0 immediately.
REQ-038 Rerun same program (110100, 011010) twice -> identical rsp_data sequences; clear then start -> empty-run behaviour.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU opcode sequencer.
// Response layout: {opcode, result, carry, slt, iszero}.
package alu_op_sequencer_pkg;

  localparam int OPW   = 6;
  localparam int RSP_W = 10;

  localparam int RSP_ZERO  = 0;
  localparam int RSP_SLT   = 1;
  localparam int RSP_CARRY = 2;
  localparam int RSP_RES   = 3;
  localparam int RSP_OP    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_HOLD,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Program load, run control, ALU drive/sense and response
// handshake of the opcode sequencer.
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             load_valid;
  logic [OPW-1:0]   load_opcode;
  logic             load_ready;
  logic             clear;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
  logic [OPW-1:0]   alu_opcode;
  logic             alu_result;
  logic             alu_carry;
  logic             alu_slt;
  logic             alu_iszero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RSP_W-1:0] rsp_data;

  modport master (
    input  load_valid, load_opcode,
    input  clear, start,
    input  alu_result, alu_carry,
    input  alu_slt, alu_iszero,
    input  rsp_ready,
    output load_ready, busy, done,
    output count, alu_opcode,
    output rsp_valid, rsp_data
  );

  modport slave (
    output load_valid, load_opcode,
    output clear, start,
    output alu_result, alu_carry,
    output alu_slt, alu_iszero,
    output rsp_ready,
    input  load_ready, busy, done,
    input  count, alu_opcode,
    input  rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_op_sequencer_prog_buf.sv
// Program store: DEPTH x OPW registers, one write port,
// asynchronous read port. Contents are not reset.
module alu_prog_buf
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [OPW-1:0] i_wdata,
  input  logic [AW-1:0]  i_raddr,
  output logic [OPW-1:0] o_rdata
);

  logic [OPW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps a stored opcode program through an external ALU,
// capturing each settled result into a held response.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  alu_op_sequencer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e       r_state;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_index;
  logic [OPW-1:0]   r_opcode;
  logic [SW-1:0]    r_settle;
  logic             r_rsp_valid;
  logic [RSP_W-1:0] r_rsp_data;
  logic             r_done;
  logic             r_busy;

  logic             w_idle;
  logic             w_load_ready;
  logic             w_we;
  logic             w_last;
  logic [OPW-1:0]   w_rd_data;

  assign w_idle       = (r_state == S_IDLE);
  assign w_load_ready = w_idle && (r_count < CW'(DEPTH));
  // start and clear both outrank a same-cycle write
  assign w_we   = w_load_ready && bus.load_valid &&
                  !bus.start && !bus.clear;
  assign w_last = ({1'b0, r_index} == (r_count - CW'(1)));

  alu_prog_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (bus.load_opcode),
    .i_raddr (r_index),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_index     <= '0;
      r_opcode    <= '0;
      r_settle    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_index <= '0;
            if (r_count != '0) begin
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (bus.clear) begin
            r_count <= '0;
          end else if (w_we) begin
            r_count <= r_count + CW'(1);
          end
        end
        S_ISSUE: begin
          r_opcode <= w_rd_data;
          r_settle <= SW'(SETTLE - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_rsp_data[RSP_OP +: OPW] <= r_opcode;
            r_rsp_data[RSP_RES]       <= bus.alu_result;
            r_rsp_data[RSP_CARRY]     <= bus.alu_carry;
            r_rsp_data[RSP_SLT]       <= bus.alu_slt;
            r_rsp_data[RSP_ZERO]      <= bus.alu_iszero;
            r_rsp_valid               <= 1'b1;
            r_state                   <= S_HOLD;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_index <= r_index + AW'(1);
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.count      = r_count;
  assign bus.alu_opcode = r_opcode;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: ALU model as load, scoreboard queue of
// expected responses checked with immediate assertions.
module tb_alu_op_sequencer;

  localparam int DEPTH  = 8;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] prog[$];
  logic [9:0] sb[$];
  logic [9:0] last_run[$];
  logic [9:0] run1[$];

  alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

  alu_op_sequencer #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [5:0] op);
    logic [3:0] s;
    s = {1'b0, op[5:3]} + {1'b0, op[2:0]};
    return {^op, s[3], (op[5:3] < op[2:0]), (s[2:0] == 3'd0)};
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_carry, bus.alu_slt, bus.alu_iszero}
      = alu_fn(bus.alu_opcode);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [5:0] op, input logic acc);
    chk("load_ready", 32'(bus.load_ready), 32'(acc));
    bus.load_valid  = 1'b1;
    bus.load_opcode = op;
    tick();
    bus.load_valid  = 1'b0;
    if (acc) prog.push_back(op);
    chk("count", 32'(bus.count), 32'(prog.size()));
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    prog.delete();
    chk("clear_count", 32'(bus.count), 32'd0);
  endtask

  task automatic wait_rsp(output logic ok);
    int w;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 32) begin
      tick();
      w++;
    end
    ok = (bus.rsp_valid === 1'b1);
    if (!ok) chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  // bp: response index that sees 5 cycles of backpressure (-1: none)
  task automatic run_prog(input int bp);
    logic [9:0] hd;
    logic [5:0] ho;
    logic       ok;
    sb.delete();
    last_run.delete();
    foreach (prog[i]) sb.push_back({prog[i], alu_fn(prog[i])});
    bus.rsp_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_run", 32'(bus.busy), 32'd1);
    if (prog.size() == 0) begin
      chk("empty_done", 32'(bus.done), 32'd1);
      tick();
      chk("empty_done_off", 32'(bus.done), 32'd0);
      chk("empty_busy_off", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
        chk("empty_no_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
      end
      return;
    end
    repeat (SETTLE) tick();
    chk("latency_pre", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("latency_hit", 32'(bus.rsp_valid), 32'd1);
    for (int r = 0; r < prog.size(); r++) begin
      wait_rsp(ok);
      if (!ok) return;
      chk("alu_opcode", 32'(bus.alu_opcode), 32'(prog[r]));
      if (r == bp) begin
        bus.rsp_ready = 1'b0;
        hd = bus.rsp_data;
        ho = bus.alu_opcode;
        repeat (5) tick();
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_data", 32'(bus.rsp_data), 32'(hd));
        chk("bp_opcode", 32'(bus.alu_opcode), 32'(ho));
        bus.rsp_ready = 1'b1;
      end
      chk("rsp_data", 32'(bus.rsp_data), 32'(sb.pop_front()));
      last_run.push_back(bus.rsp_data);
      tick();
      if (r == prog.size() - 1)
        chk("done_pulse", 32'(bus.done), 32'd1);
      else
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk("done_off", 32'(bus.done), 32'd0);
    chk("busy_off", 32'(bus.busy), 32'd0);
    chk("count_kept", 32'(bus.count), 32'(prog.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   w;
    rst_n           = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_opcode = '0;
    bus.clear       = 1'b0;
    bus.start       = 1'b0;
    bus.rsp_ready   = 1'b1;
    repeat (2) tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_load_ready", 32'(bus.load_ready), 32'd1);

    // basic three-opcode program, then same program with backpressure
    load(6'b000011, 1'b1);
    load(6'b000100, 1'b1);
    load(6'b001011, 1'b1);
    run_prog(-1);
    run_prog(1);

    // clear outranks a same-cycle write
    bus.clear       = 1'b1;
    bus.load_valid  = 1'b1;
    bus.load_opcode = 6'b111111;
    tick();
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    prog.delete();
    chk("clear_prio", 32'(bus.count), 32'd0);

    // full buffer: ninth write dropped, full run
    for (int i = 0; i < DEPTH; i++) load(6'(i * 7 + 5), 1'b1);
    chk("full_ready", 32'(bus.load_ready), 32'd0);
    load(6'b011010, 1'b0);
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    run_prog(-1);

    // empty program
    do_clear();
    run_prog(-1);

    // reset during SETTLE of second opcode
    load(6'b000111, 1'b1);
    load(6'b110001, 1'b1);
    load(6'b101010, 1'b1);
    bus.rsp_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_rsp(ok);
    chk("rst_first_rsp", 32'(bus.rsp_data),
        32'({6'b000111, alu_fn(6'b000111)}));
    tick();
    w = 0;
    while (bus.alu_opcode !== 6'b110001 && w < 10) begin
      tick();
      w++;
    end
    chk("rst_in_settle", 32'(bus.alu_opcode), 32'(6'b110001));
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_opcode", 32'(bus.alu_opcode), 32'd0);
    tick();
    rst_n = 1'b1;
    prog.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_quiet", 32'(bus.rsp_valid), 32'd0);
    end

    // reset while a response is held drops rsp_valid at once
    load(6'b010101, 1'b1);
    bus.rsp_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_rsp(ok);
    rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold_rst_data", 32'(bus.rsp_data), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    prog.delete();
    tick();

    // rerun repeats the identical sequence
    load(6'b110100, 1'b1);
    load(6'b011010, 1'b1);
    run_prog(-1);
    run1 = last_run;
    run_prog(-1);
    chk("rerun_len", 32'(last_run.size()), 32'(run1.size()));
    foreach (run1[i]) begin
      if (i < last_run.size())
        chk("rerun_data", 32'(last_run[i]), 32'(run1[i]));
    end

    do_clear();
    run_prog(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
